rd_ptr_empty: RTL and testbench
===============================

# rd_ptr_empty

Read-domain pointer and empty-flag generator for the asynchronous FIFO, the counterpart to the write-domain full logic. It brings the Gray-coded write pointer into the read clock domain through an internal two-flop synchronizer. It then advances the read pointer on accepted reads and drives the memory read address. It publishes the Gray read pointer back to the write domain, along with registered empty, almost-empty and fill-level status.

## Interface

Parameters:
- WIDTH, 8, address bits; FIFO depth is 2^WIDTH; pointers are WIDTH+1 bits.
- AE_LEVEL, 4, almost-empty threshold in entries (0..2^WIDTH).

Ports:
- i_RD_clk  input  1  read-domain clock; every register in the block is clocked on its rising edge.
- i_RD_rst_n  input  1  reset, asynchronous, active-low.
- i_RD_En  input  1  read request from the consumer.
- i_WR_Ptr  input  WIDTH+1  Gray-coded write pointer from the write clock domain; unsynchronized.
- o_RD_Addr  output  WIDTH  memory read address of the current head entry.
- o_RD_Ptr  output  WIDTH+1  registered Gray read pointer, sent to the write domain.
- o_Empty  output  1  registered empty flag.
- o_Almost_Empty  output  1  registered flag; high when the level is at or below AE_LEVEL.
- o_RD_Level  output  WIDTH+1  registered occupancy as seen from the read domain (0..2^WIDTH).
- o_RD_Ack  output  1  one-cycle pulse, one edge after a read is accepted.

## Operation

Synchronizer:
- Two stages, r_WR_s1 <= i_WR_Ptr and r_WR_s2 <= r_WR_s1.
- Both stages reset to 0.
- Only r_WR_s2 is used by downstream logic.

Read pointer:
- Read fire: w_Fire = i_RD_En & ~o_Empty.
- A read while empty is ignored: no pointer change, no ack, no underflow.
- Next binary pointer: w_Bin_Next = r_Bin + w_Fire, modulo 2^(WIDTH+1).
- Next Gray pointer: w_Gray_Next = (w_Bin_Next >> 1) ^ w_Bin_Next.
- r_Bin <= w_Bin_Next and o_RD_Ptr <= w_Gray_Next.
- o_RD_Addr = r_Bin[WIDTH-1:0], combinational from the register. This is the address of the entry that will be taken on the next fire.

Status:
- Empty: o_Empty <= (w_Gray_Next == r_WR_s2).
- Write pointer in binary: w_WR_Bin = Gray-to-binary of r_WR_s2, computed by an XOR prefix from the MSB down.
- Level: o_RD_Level <= w_WR_Bin - w_Bin_Next, modulo 2^(WIDTH+1).
- Almost empty: o_Almost_Empty <= (level_next <= AE_LEVEL), with level_next evaluated at full WIDTH+1 bits.
- Ack: o_RD_Ack <= w_Fire.
- Invariant: o_Empty == (o_RD_Level == 0) on every cycle.

Reset:
- While i_RD_rst_n is low, all registers clear immediately and independently of the clock.
- Output values in reset: o_RD_Ptr=0, o_RD_Addr=0, o_RD_Level=0, o_RD_Ack=0, o_Empty=1, o_Almost_Empty=1.
- Reset mid-operation discards the pointer and synchronizer contents; there is no partial state.

Boundary rules:
- Wrap-around: the binary pointer rolls from 2^(WIDTH+1)-1 to 0. The Gray pointer changes exactly one bit on every increment, including the rollover.
- The MSB of o_RD_Ptr toggles once every 2^WIDTH reads.
- Full FIFO: the synced pointers differ in their top two Gray bits. o_RD_Level = 2^WIDTH, and reads proceed normally.
- Simultaneous last read and new write arrival: empty is computed against the current r_WR_s2.
  - If the write has not yet reached r_WR_s2, o_Empty asserts for the cycle(s) until it arrives.
- Empty and level are pessimistic: they may under-report data, but never over-report it.

## Timing

- Write-pointer latency: a change on i_WR_Ptr before edge N is captured in r_WR_s1 at N and r_WR_s2 at N+1. It is reflected in o_Empty, o_RD_Level and o_Almost_Empty at edge N+2.
- Read latency: with i_RD_En high and o_Empty low before edge N, at edge N:
  - r_Bin, o_RD_Addr and o_RD_Ptr advance;
  - o_RD_Ack goes high for one cycle;
  - the status outputs update.
- Back-to-back reads: one read per cycle sustained while o_Empty is low. The read that empties the FIFO sets o_Empty at that same edge, so the following cycle's request is ignored.
- o_RD_Ptr is flop-driven with no combinational path from inputs, as required for safe crossing.

## Test plan

- Reset: assert i_RD_rst_n low mid-clock -> outputs immediately read o_Empty=1, o_Almost_Empty=1, o_RD_Level=0, o_RD_Ptr=0, o_RD_Addr=0, o_RD_Ack=0.
- Sync latency (WIDTH=3): drive i_WR_Ptr 0 -> 1 before edge N -> o_Empty falls and o_RD_Level=1 at edge N+2. A one-cycle i_RD_En then gives o_RD_Ack=1, o_RD_Ptr=1, o_RD_Addr=1 and o_Empty=1.
- Underflow: hold i_RD_En high for 5 cycles while empty -> o_RD_Ptr stays 0 and o_RD_Ack stays 0.
- Full and wrap (WIDTH=3): set i_WR_Ptr=4'b1100 (binary 8), giving o_RD_Level=8. Then 8 consecutive reads give:
  - o_RD_Ptr sequence 1,3,2,6,7,5,4,C;
  - o_RD_Addr 1..7 then 0;
  - o_Empty=1 after the 8th read.
  - A further 8 writes and 8 reads then return o_RD_Ptr to 0.
- Almost empty (AE_LEVEL=2): level 5, read continuously -> o_Almost_Empty rises at the edge where the level becomes 2, stays high at 1 and 0, and falls when the level returns to 3.
- Reset mid-operation: with level 3 and reads in progress, pulse reset -> all outputs return to reset values; after release with i_WR_Ptr=0, the block stays empty.

Source files
------------

// File: rtl/rd_ptr_empty.sv
// rd_ptr_empty
// Read-domain pointer and empty-flag generator for an asynchronous FIFO.
// The Gray write pointer is brought into the read domain through a two-flop
// synchronizer. The read pointer advances on accepted reads. Empty,
// almost-empty and level are produced as registered status.
//
// Ports
//   i_RD_clk        read-domain clock
//   i_RD_rst_n      asynchronous active-low reset
//   i_RD_En         read request from the consumer
//   i_WR_Ptr        Gray write pointer from the write domain (unsynchronized)
//   o_RD_Addr       memory address of the current head entry
//   o_RD_Ptr        registered Gray read pointer, sent to the write domain
//   o_Empty         registered empty flag
//   o_Almost_Empty  registered flag, high when the level is at or below AE_LEVEL
//   o_RD_Level      registered occupancy seen from the read domain
//   o_RD_Ack        one-cycle pulse for each accepted read
module rd_ptr_empty #(
    parameter int WIDTH    = 8,
    parameter int AE_LEVEL = 4
) (
    input  logic             i_RD_clk,
    input  logic             i_RD_rst_n,
    input  logic             i_RD_En,
    input  logic [WIDTH:0]   i_WR_Ptr,
    output logic [WIDTH-1:0] o_RD_Addr,
    output logic [WIDTH:0]   o_RD_Ptr,
    output logic             o_Empty,
    output logic             o_Almost_Empty,
    output logic [WIDTH:0]   o_RD_Level,
    output logic             o_RD_Ack
);

    localparam logic [WIDTH:0] AE_THR = AE_LEVEL[WIDTH:0];

    logic [WIDTH:0] r_WR_s1;
    logic [WIDTH:0] r_WR_s2;
    logic [WIDTH:0] r_Bin;

    logic           w_Fire;
    logic [WIDTH:0] w_Bin_Next;
    logic [WIDTH:0] w_Gray_Next;
    logic [WIDTH:0] w_WR_Bin;
    logic [WIDTH:0] w_Level_Next;

    // Reads while empty are dropped here, so the pointer can never pass the
    // synchronized write pointer.
    assign w_Fire      = i_RD_En & ~o_Empty;
    assign w_Bin_Next  = r_Bin + {{WIDTH{1'b0}}, w_Fire};
    assign w_Gray_Next = (w_Bin_Next >> 1) ^ w_Bin_Next;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_WR_Bin = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            w_WR_Bin[i] = ^(r_WR_s2 >> i);
        end
    end

    // The synchronized write pointer lags the true one, so the level can only
    // under-report what is stored.
    assign w_Level_Next = w_WR_Bin - w_Bin_Next;

    assign o_RD_Addr = r_Bin[WIDTH-1:0];

    always_ff @(posedge i_RD_clk or negedge i_RD_rst_n) begin
        if (!i_RD_rst_n) begin
            r_WR_s1 <= '0;
            r_WR_s2 <= '0;
        end else begin
            r_WR_s1 <= i_WR_Ptr;
            r_WR_s2 <= r_WR_s1;
        end
    end

    always_ff @(posedge i_RD_clk or negedge i_RD_rst_n) begin
        if (!i_RD_rst_n) begin
            r_Bin          <= '0;
            o_RD_Ptr       <= '0;
            o_Empty        <= 1'b1;
            o_Almost_Empty <= 1'b1;
            o_RD_Level     <= '0;
            o_RD_Ack       <= 1'b0;
        end else begin
            r_Bin          <= w_Bin_Next;
            o_RD_Ptr       <= w_Gray_Next;
            o_Empty        <= (w_Gray_Next == r_WR_s2);
            o_Almost_Empty <= (w_Level_Next <= AE_THR);
            o_RD_Level     <= w_Level_Next;
            o_RD_Ack       <= w_Fire;
        end
    end

endmodule

// File: tb/tb_rd_ptr_empty.sv
module tb_rd_ptr_empty;

    localparam int W  = 3;
    localparam int AE = 2;
    localparam int PMOD = 16;  // pointer modulus 2^(W+1)

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] wr_ptr;
    logic [2:0] rd_addr;
    logic [3:0] rd_ptr;
    logic       empty;
    logic       almost_empty;
    logic [3:0] rd_level;
    logic       rd_ack;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;   // total entries written (binary count)
    bit chk_en = 0;

    // model state: reads taken, two-stage delay of the write count, status
    int m_rd, m_s1, m_s2, m_level, m_ack;
    int m_fire, m_rd_next;

    function automatic int gray(int b);
        return b ^ (b >> 1);
    endfunction

    assign wr_ptr = 4'(gray(wr_cnt % PMOD));

    rd_ptr_empty #(.WIDTH(W), .AE_LEVEL(AE)) dut (
        .i_RD_clk      (clk),
        .i_RD_rst_n    (rst_n),
        .i_RD_En       (en),
        .i_WR_Ptr      (wr_ptr),
        .o_RD_Addr     (rd_addr),
        .o_RD_Ptr      (rd_ptr),
        .o_Empty       (empty),
        .o_Almost_Empty(almost_empty),
        .o_RD_Level    (rd_level),
        .o_RD_Ack      (rd_ack)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Behavioural model: a FIFO is counts of writes and reads; the read domain
    // sees the write count two edges late; a read is taken only when data is seen.
    assign m_fire    = (en && m_level != 0) ? 1 : 0;
    assign m_rd_next = (m_rd + m_fire) % PMOD;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rd <= 0; m_s1 <= 0; m_s2 <= 0; m_level <= 0; m_ack <= 0;
        end else begin
            m_rd    <= m_rd_next;
            m_ack   <= m_fire;
            m_level <= (m_s2 - m_rd_next + PMOD) % PMOD;
            m_s2    <= m_s1;
            m_s1    <= wr_cnt % PMOD;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ptr",   int'(rd_ptr),       gray(m_rd));
            check("model_addr",  int'(rd_addr),      m_rd % 8);
            check("model_level", int'(rd_level),     m_level);
            check("model_empty", int'(empty),        (m_level == 0) ? 1 : 0);
            check("model_ae",    int'(almost_empty), (m_level <= AE) ? 1 : 0);
            check("model_ack",   int'(rd_ack),       m_ack);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check({tag, "_empty"}, int'(empty), 1);
        check({tag, "_ae"},    int'(almost_empty), 1);
        check({tag, "_level"}, int'(rd_level), 0);
        check({tag, "_ptr"},   int'(rd_ptr), 0);
        check({tag, "_addr"},  int'(rd_addr), 0);
        check({tag, "_ack"},   int'(rd_ack), 0);
        wr_cnt = 0;
        en = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    int ptr_seq [8] = '{1, 3, 2, 6, 7, 5, 4, 12};
    int addr_seq[8] = '{1, 2, 3, 4, 5, 6, 7, 0};
    int ae_seq  [5] = '{0, 0, 1, 1, 1};
    int lvl_seq [5] = '{4, 3, 2, 1, 0};

    initial begin
        rst_n = 0;
        en = 0;
        step(2);
        rst_n = 1;
        chk_en = 1;
        step(2);

        pulse_reset("rst");

        // underflow: reads while empty are ignored
        en = 1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("uf_ptr", int'(rd_ptr), 0);
            check("uf_ack", int'(rd_ack), 0);
        end
        en = 0;

        // synchronizer latency: write seen on status two edges after capture
        wr_cnt = 1;
        step(1);
        check("sync_n_empty", int'(empty), 1);
        step(1);
        check("sync_n1_empty", int'(empty), 1);
        step(1);
        check("sync_n2_empty", int'(empty), 0);
        check("sync_n2_level", int'(rd_level), 1);
        en = 1;
        step(1);
        en = 0;
        check("rd1_ack",   int'(rd_ack), 1);
        check("rd1_ptr",   int'(rd_ptr), 1);
        check("rd1_addr",  int'(rd_addr), 1);
        check("rd1_empty", int'(empty), 1);
        step(1);
        check("rd1_ack_end", int'(rd_ack), 0);

        // full FIFO and pointer wrap
        pulse_reset("rst_full");
        wr_cnt = 8;
        step(3);
        check("full_level", int'(rd_level), 8);
        check("full_empty", int'(empty), 0);
        en = 1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("wrap_ptr",  int'(rd_ptr),  ptr_seq[i]);
            check("wrap_addr", int'(rd_addr), addr_seq[i]);
        end
        en = 0;
        check("wrap_empty", int'(empty), 1);
        wr_cnt = 16;
        step(3);
        check("wrap2_level", int'(rd_level), 8);
        en = 1;
        step(8);
        en = 0;
        check("wrap2_ptr",   int'(rd_ptr), 0);
        check("wrap2_empty", int'(empty), 1);
        step(1);

        // almost-empty threshold
        pulse_reset("rst_ae");
        wr_cnt = 5;
        step(3);
        check("ae_l5_level", int'(rd_level), 5);
        check("ae_l5",       int'(almost_empty), 0);
        en = 1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("ae_drain_level", int'(rd_level), lvl_seq[i]);
            check("ae_drain",       int'(almost_empty), ae_seq[i]);
        end
        en = 0;
        wr_cnt = 8;
        step(3);
        check("ae_l3_level", int'(rd_level), 3);
        check("ae_l3",       int'(almost_empty), 0);

        // reset in the middle of a read burst
        pulse_reset("rst_pre");
        wr_cnt = 5;
        step(3);
        en = 1;
        step(2);
        check("mid_level", int'(rd_level), 3);
        pulse_reset("rst_mid");
        step(4);
        check("post_empty", int'(empty), 1);
        check("post_level", int'(rd_level), 0);
        check("post_ptr",   int'(rd_ptr), 0);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
